rx_medida_serial: RTL and testbench

Serial receiver and frame parser for the ultrasonic distance path; it consumes the ASCII measurement stream that the sensor top level emits on `saida_serial`. It deserialises 7O1 UART characters and assembles each `ddd#` frame into a 12-bit BCD distance. It raises `pronto` when a frame completes and `erro` when a frame is malformed. It sits on the host/receiving board, or in a loopback test top, directly downstream of the sensor transmitter.

---
 rtl/rx_medida_serial_pkg.sv | 31 +++
 rtl/rx_medida_serial_rx.sv | 105 ++++++++++
 rtl/rx_medida_serial.sv | 101 ++++++++++
 tb/tb_rx_medida_serial.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rx_medida_serial_pkg.sv
// Shared constants and state/status encodings for the 7O1 receiver and
// the ddd# measurement frame parser.
package rx_medida_serial_pkg;

  localparam logic [6:0] ASCII_ZERO = 7'h30;
  localparam logic [6:0] ASCII_NINE = 7'h39;
  localparam logic [6:0] ASCII_HASH = 7'h23;

  typedef enum logic [2:0] {
    INATIVO,
    START,
    DADOS,
    PARIDADE,
    STOP
  } rx_state_t;

  // Encodings double as the debug display code on db_estado.
  typedef enum logic [1:0] {
    ESPERA_C    = 2'd0,
    ESPERA_D    = 2'd1,
    ESPERA_U    = 2'd2,
    ESPERA_HASH = 2'd3
  } parse_state_t;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_PARIDADE = 2'd1,
    ST_FRAME    = 2'd2
  } rx_status_t;

endpackage

// File: rtl/rx_medida_serial_rx.sv
// 7O1 UART character receiver: synchroniser, mid-bit sampling, shift
// register and parity/stop check, emitting a one-cycle character strobe.
module rx_serial_7O1
  import rx_medida_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] dado,
  output logic [1:0] status,
  output logic       strobe
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic          sync1, sync2;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    nbits;
  logic [6:0]    shreg;
  logic          par;
  rx_status_t    status_q;

  assign status = status_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= entrada_serial;
      sync2 <= sync1;
    end
  end

  // The counter restarts at every sample, so each bit is timed from the
  // previous mid-bit point rather than from the start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= INATIVO;
      cnt      <= '0;
      nbits    <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      dado     <= '0;
      status_q <= ST_OK;
      strobe   <= 1'b0;
    end else begin
      strobe <= 1'b0;
      case (state)
        INATIVO: begin
          cnt <= '0;
          if (!sync2) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            nbits <= '0;
            state <= sync2 ? INATIVO : DADOS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DADOS: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shreg <= {sync2, shreg[6:1]};
            if (nbits == 3'd6) state <= PARIDADE;
            else nbits <= nbits + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARIDADE: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            par   <= sync2;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt    <= '0;
            state  <= INATIVO;
            dado   <= shreg;
            strobe <= 1'b1;
            if (!sync2) status_q <= ST_FRAME;
            else if (^{shreg, par}) status_q <= ST_OK;
            else status_q <= ST_PARIDADE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= INATIVO;
      endcase
    end
  end

endmodule

// File: rtl/rx_medida_serial.sv
// Receives the sensor's ASCII stream and assembles "ddd#" frames into a
// 12-bit BCD distance, flagging malformed frames.
module rx_medida_serial
  import rx_medida_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [6:0]  db_dado,
  output logic [3:0]  db_estado
);

  logic [6:0]   rx_dado;
  logic [1:0]   rx_status;
  logic         rx_strobe;
  parse_state_t estado;
  logic [3:0]   dig_c, dig_d, dig_u;
  logic         is_digit;

  rx_serial_7O1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock         (clock),
    .reset         (reset),
    .entrada_serial(entrada_serial),
    .dado          (rx_dado),
    .status        (rx_status),
    .strobe        (rx_strobe)
  );

  assign is_digit  = (rx_dado >= ASCII_ZERO) && (rx_dado <= ASCII_NINE);
  assign db_estado = {2'b00, estado};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado  <= ESPERA_C;
      dig_c   <= '0;
      dig_d   <= '0;
      dig_u   <= '0;
      medida  <= '0;
      pronto  <= 1'b0;
      erro    <= 1'b0;
      db_dado <= '0;
    end else begin
      pronto <= 1'b0;
      erro   <= 1'b0;
      if (rx_strobe) begin
        db_dado <= rx_dado;
        if (rx_status != ST_OK) begin
          erro   <= 1'b1;
          estado <= ESPERA_C;
        end else begin
          case (estado)
            ESPERA_C: begin
              if (is_digit) begin
                dig_c  <= 4'(rx_dado - ASCII_ZERO);
                estado <= ESPERA_D;
              end else begin
                erro <= 1'b1;
              end
            end
            ESPERA_D: begin
              if (is_digit) begin
                dig_d  <= 4'(rx_dado - ASCII_ZERO);
                estado <= ESPERA_U;
              end else begin
                erro   <= 1'b1;
                estado <= ESPERA_C;
              end
            end
            ESPERA_U: begin
              if (is_digit) begin
                dig_u  <= 4'(rx_dado - ASCII_ZERO);
                estado <= ESPERA_HASH;
              end else begin
                erro   <= 1'b1;
                estado <= ESPERA_C;
              end
            end
            ESPERA_HASH: begin
              if (rx_dado == ASCII_HASH) begin
                medida <= {dig_c, dig_d, dig_u};
                pronto <= 1'b1;
              end else begin
                erro <= 1'b1;
              end
              estado <= ESPERA_C;
            end
            default: estado <= ESPERA_C;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_medida_serial.sv
// Bench for rx_medida_serial: character-level frame model plus a per-cycle
// compare process on the pronto/erro/medida outputs.
module tb_rx_medida_serial;

  localparam int unsigned CPB    = 40;
  localparam int unsigned GLITCH = CPB / 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        entrada_serial = 1'b1;
  logic [11:0] medida;
  logic        pronto, erro;
  logic [6:0]  db_dado;
  logic [3:0]  db_estado;

  rx_medida_serial #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .entrada_serial(entrada_serial),
    .medida        (medida),
    .pronto        (pronto),
    .erro          (erro),
    .db_dado       (db_dado),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ok;
    logic [11:0] med;
    logic [6:0]  ch;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned rd = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [3:0]  m_dig[$];
  logic [11:0] model_medida;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame rules applied to one received character.
  task automatic model_char(input logic [6:0] c, input bit bad);
    ev_t e;
    e.ch  = c;
    e.med = '0;
    e.ok  = 1'b0;
    if (bad) begin
      exp_q.push_back(e);
      m_dig.delete();
    end else if (m_dig.size() < 3 && c >= 7'h30 && c <= 7'h39) begin
      m_dig.push_back(4'(c - 7'h30));
    end else if (m_dig.size() == 3 && c == 7'h23) begin
      e.ok  = 1'b1;
      e.med = {m_dig[0], m_dig[1], m_dig[2]};
      exp_q.push_back(e);
      m_dig.delete();
    end else begin
      exp_q.push_back(e);
      m_dig.delete();
    end
  endtask

  task automatic drive_bit(input logic b);
    entrada_serial = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_char(input logic [6:0] c, input bit bad_par, input bit bad_stop,
                           input int unsigned gap);
    logic p;
    p = ~^c;
    if (bad_par) p = ~p;
    model_char(c, bad_par || bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(c[i]);
    drive_bit(p);
    drive_bit(!bad_stop);
    for (int unsigned g = 0; g < gap; g++) drive_bit(1'b1);
    chk("db_dado_after_char", 32'(db_dado), 32'(c));
    chk("db_estado_after_char", 32'(db_estado), 32'(m_dig.size()));
  endtask

  task automatic send_str(input string s, input int unsigned gap);
    for (int i = 0; i < s.len(); i++) send_char(7'(s[i]), 1'b0, 1'b0, gap);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 * CPB && rd != exp_q.size(); i++) @(negedge clock);
    chk(name, rd, exp_q.size());
  endtask

  task automatic do_reset();
    entrada_serial = 1'b1;
    reset = 1'b1;
    m_dig.delete();
    repeat (3) @(negedge clock);
    chk("rst_medida", 32'(medida), 0);
    chk("rst_pronto", 32'(pronto), 0);
    chk("rst_erro", 32'(erro), 0);
    chk("rst_db_dado", 32'(db_dado), 0);
    chk("rst_db_estado", 32'(db_estado), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Compare process: every pulse must match the next modelled frame event.
  initial begin
    model_medida = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        model_medida = '0;
        rd = exp_q.size();
      end else begin
        chk("pronto_erro_exclusive", 32'(pronto & erro), 0);
        if (pronto || erro) begin
          if (rd >= exp_q.size()) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: pronto=%b erro=%b with no event expected (t=%0t)",
                     pronto, erro, $time);
          end else begin
            ev_t e;
            e = exp_q[rd];
            rd++;
            chk("pulse_is_pronto", 32'(pronto), 32'(e.ok));
            chk("pulse_db_dado", 32'(db_dado), 32'(e.ch));
            chk("pulse_db_estado", 32'(db_estado), 0);
            if (e.ok) model_medida = e.med;
          end
        end
        chk("medida", 32'(medida), 32'(model_medida));
      end
    end
  end

  initial begin
    @(negedge clock);
    do_reset();

    send_str("123#", 1);
    wait_idle("drain_123");
    chk("lit_medida_123", 32'(medida), 32'h123);
    chk("lit_estado_123", 32'(db_estado), 0);

    send_char(7'h31, 1'b0, 1'b0, 1);
    send_char(7'h32, 1'b0, 1'b0, 1);
    send_char(7'h34, 1'b1, 1'b0, 1);
    wait_idle("drain_parity");
    chk("lit_medida_after_parity", 32'(medida), 32'h123);
    send_str("045#", 0);
    wait_idle("drain_045");
    chk("lit_medida_045", 32'(medida), 32'h045);

    send_str("12#", 1);
    send_str("987#", 1);
    wait_idle("drain_987");
    chk("lit_medida_987", 32'(medida), 32'h987);

    entrada_serial = 1'b0;
    repeat (GLITCH) @(negedge clock);
    entrada_serial = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    chk("glitch_db_dado", 32'(db_dado), 32'h23);
    send_str("001#", 1);
    wait_idle("drain_001");
    chk("lit_medida_001", 32'(medida), 32'h001);

    send_char(7'h35, 1'b0, 1'b0, 0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    do_reset();
    send_str("300#", 1);
    wait_idle("drain_300");
    chk("lit_medida_300", 32'(medida), 32'h300);

    send_str("999#", 0);
    send_str("000#", 0);
    send_char(7'h37, 1'b0, 1'b0, 0);
    send_char(7'h38, 1'b0, 1'b0, 0);
    send_char(7'h39, 1'b0, 1'b1, 2);
    wait_idle("drain_b2b");
    chk("lit_medida_000", 32'(medida), 32'h000);

    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < 4; k++) begin
        logic [6:0]  c;
        bit          bp, bs;
        int unsigned gap;
        c = (k == 3) ? 7'h23 : 7'(7'h30 + $urandom_range(0, 9));
        if ($urandom_range(0, 9) == 0) c = 7'($urandom_range(0, 127));
        bp  = ($urandom_range(0, 15) == 0);
        bs  = !bp && ($urandom_range(0, 24) == 0);
        gap = $urandom_range(0, 2);
        if (bs && gap == 0) gap = 1;
        send_char(c, bp, bs, gap);
      end
    end
    wait_idle("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
